// File: rtl/choice_pkg.sv
// choice_pkg: shared types and helpers for the choice-table predictor.
// Holds the FSM state enum, select-bit meanings and the counter update rule.
package choice_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic LOCAL  = 1'b0;
  localparam logic GLOBAL = 1'b1;

  // Saturating choice-counter step; ctr_max is 2^CTR_BITS-1.
  function automatic int ctr_next(
    input int   ctr,
    input int   ctr_max,
    input logic local_correct,
    input logic global_correct
  );
    int nxt;
    nxt = ctr;
    case ({global_correct, local_correct})
      2'b10: if (ctr < ctr_max) nxt = ctr + 1;
      2'b01: if (ctr > 0)       nxt = ctr - 1;
      default: nxt = ctr;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/choice_ctr_table.sv
// choice_ctr_table: 2^HIST_BITS x CTR_BITS counter storage, no reset.
// Ports: lookup read (raddr/rdata, write-first), update read (uaddr/udata), write (we/waddr/wdata).
module choice_ctr_table
  import choice_pkg::*;
#(
  parameter int HIST_BITS = 12,
  parameter int CTR_BITS  = 2
) (
  input  logic                 clock,
  input  logic [HIST_BITS-1:0] raddr,
  output logic [CTR_BITS-1:0]  rdata,
  input  logic [HIST_BITS-1:0] uaddr,
  output logic [CTR_BITS-1:0]  udata,
  input  logic                 we,
  input  logic [HIST_BITS-1:0] waddr,
  input  logic [CTR_BITS-1:0]  wdata
);

  logic [CTR_BITS-1:0] mem [2**HIST_BITS];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  // A same-cycle write to the looked-up entry is forwarded.
  assign rdata = (we && (waddr == raddr)) ? wdata : mem[raddr];

  // Read half of the update read-modify-write.
  assign udata = mem[uaddr];

endmodule

// File: rtl/choice_table_predictor.sv
// choice_table_predictor: GHR-indexed choice counters (local vs global), init sweep after reset/flush.
// Ports: clock, reset(n), flush, ready, lookup_valid -> pred_*, update_* training.
module choice_table_predictor
  import choice_pkg::*;
#(
  parameter int HIST_BITS = 12,
  parameter int CTR_BITS  = 2,
  parameter int CTR_INIT  = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 flush,
  output logic                 ready,
  input  logic                 lookup_valid,
  output logic                 pred_valid,
  output logic                 pred_use_global,
  output logic [HIST_BITS-1:0] pred_index,
  input  logic                 update_valid,
  input  logic [HIST_BITS-1:0] update_index,
  input  logic                 update_local_correct,
  input  logic                 update_global_correct,
  input  logic                 update_taken
);

  localparam int CTR_MAX = (1 << CTR_BITS) - 1;
  localparam logic [HIST_BITS-1:0] LAST = '1;
  localparam logic [CTR_BITS-1:0] INIT_VAL = CTR_BITS'(CTR_INIT);

  state_t state_q, state_d;

  logic [HIST_BITS-1:0] init_ptr;
  logic [HIST_BITS-1:0] ghr;
  logic [HIST_BITS-1:0] waddr;
  logic [CTR_BITS-1:0]  wdata;
  logic [CTR_BITS-1:0]  rdata;
  logic [CTR_BITS-1:0]  udata;
  logic run;
  logic lookup_fire;
  logic update_fire;
  logic we;

  assign run         = (state_q == RUN);
  assign ready       = run;
  assign lookup_fire = run && lookup_valid && !flush;
  assign update_fire = run && update_valid && !flush;

  // Single write port: sweep owns it in INIT, training in RUN.
  assign we    = flush ? 1'b0 : (run ? update_valid : 1'b1);
  assign waddr = run ? update_index : init_ptr;
  assign wdata = run
    ? CTR_BITS'(ctr_next(int'(udata), CTR_MAX,
                         update_local_correct,
                         update_global_correct))
    : INIT_VAL;

  choice_ctr_table #(
    .HIST_BITS(HIST_BITS),
    .CTR_BITS (CTR_BITS)
  ) u_table (
    .clock(clock),
    .raddr(ghr),
    .rdata(rdata),
    .uaddr(update_index),
    .udata(udata),
    .we   (we),
    .waddr(waddr),
    .wdata(wdata)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      INIT: if (init_ptr == LAST) state_d = RUN;
      RUN:  state_d = RUN;
    endcase
    if (flush) state_d = INIT;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= INIT;
      init_ptr <= '0;
      ghr      <= '0;
    end else begin
      state_q <= state_d;
      if (flush) begin
        init_ptr <= '0;
        ghr      <= '0;
      end else begin
        // Pointer wraps to 0 on the last sweep write.
        if (!run) init_ptr <= init_ptr + HIST_BITS'(1);
        if (update_fire) ghr <= {ghr[HIST_BITS-2:0], update_taken};
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pred_valid      <= 1'b0;
      pred_use_global <= LOCAL;
      pred_index      <= '0;
    end else begin
      pred_valid <= lookup_fire;
      if (lookup_fire) begin
        pred_index      <= ghr;
        pred_use_global <= rdata[CTR_BITS-1];
      end
    end
  end

endmodule

// File: tb/tb_choice_table_predictor.sv
// tb_choice_table_predictor: directed vectors, HIST_BITS=4, hand-computed expectations.
// Covers reset, sweep timing, training/saturation, GHR shift, bypass, flush, mid-sweep reset.
module tb_choice_table_predictor;

  localparam int HB = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          flush;
  logic          ready;
  logic          lookup_valid;
  logic          pred_valid;
  logic          pred_use_global;
  logic [HB-1:0] pred_index;
  logic          update_valid;
  logic [HB-1:0] update_index;
  logic          update_local_correct;
  logic          update_global_correct;
  logic          update_taken;

  int vectors = 0;
  int miscompares = 0;

  choice_table_predictor #(
    .HIST_BITS(HB),
    .CTR_BITS (2),
    .CTR_INIT (1)
  ) dut (
    .clock                (clock),
    .reset                (reset),
    .flush                (flush),
    .ready                (ready),
    .lookup_valid         (lookup_valid),
    .pred_valid           (pred_valid),
    .pred_use_global      (pred_use_global),
    .pred_index           (pred_index),
    .update_valid         (update_valid),
    .update_index         (update_index),
    .update_local_correct (update_local_correct),
    .update_global_correct(update_global_correct),
    .update_taken         (update_taken)
  );

  always #5 clock = ~clock;

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    flush                 = 1'b0;
    lookup_valid          = 1'b0;
    update_valid          = 1'b0;
    update_index          = '0;
    update_local_correct  = 1'b0;
    update_global_correct = 1'b0;
    update_taken          = 1'b0;
  endtask

  task automatic set_upd(input logic [HB-1:0] idx, input logic lc,
                         input logic gc, input logic t);
    update_valid          = 1'b1;
    update_index          = idx;
    update_local_correct  = lc;
    update_global_correct = gc;
    update_taken          = t;
  endtask

  task automatic upd(input logic [HB-1:0] idx, input logic lc,
                     input logic gc, input logic t);
    set_upd(idx, lc, gc, t);
    tick();
    idle();
  endtask

  task automatic chk_pred(input string tag, input int eidx, input int eg);
    check({tag, ".valid"}, pred_valid, 1);
    check({tag, ".index"}, pred_index, eidx);
    check({tag, ".global"}, pred_use_global, eg);
  endtask

  task automatic look(input string tag, input int eidx, input int eg);
    lookup_valid = 1'b1;
    tick();
    idle();
    chk_pred(tag, eidx, eg);
  endtask

  task automatic look_upd(input string tag, input logic [HB-1:0] idx,
                          input logic lc, input logic gc, input logic t,
                          input int eidx, input int eg);
    lookup_valid = 1'b1;
    set_upd(idx, lc, gc, t);
    tick();
    idle();
    chk_pred(tag, eidx, eg);
  endtask

  // Loads GHR with v using no-change updates on entry 15.
  task automatic set_ghr(input logic [HB-1:0] v);
    for (int i = HB - 1; i >= 0; i--) upd(4'd15, 1'b0, 1'b0, v[i]);
  endtask

  task automatic wait_ready(input string tag, input int exp);
    int n;
    n = 0;
    while (!ready && n < 40) begin
      tick();
      n++;
    end
    check(tag, n, exp);
  endtask

  initial begin
    reset = 1'b0;
    idle();
    tick();
    tick();
    check("rst.ready", ready, 0);
    check("rst.pred_valid", pred_valid, 0);
    check("rst.pred_index", pred_index, 0);
    check("rst.pred_global", pred_use_global, 0);

    reset = 1'b1;
    wait_ready("sweep_cycles", 16);

    look("look0", 0, 0);
    tick();
    check("pv_drop", pred_valid, 0);

    upd(4'd5, 1'b0, 1'b1, 1'b1);
    upd(4'd5, 1'b0, 1'b1, 1'b0);
    upd(4'd5, 1'b0, 1'b1, 1'b1);
    look("sat_hi", 5, 1);

    upd(4'd5, 1'b1, 1'b0, 1'b0);
    upd(4'd5, 1'b1, 1'b0, 1'b1);
    upd(4'd5, 1'b1, 1'b0, 1'b0);
    upd(4'd5, 1'b1, 1'b0, 1'b1);
    look("sat_lo", 5, 0);

    upd(4'd5, 1'b0, 1'b1, 1'b0);
    upd(4'd5, 1'b1, 1'b1, 1'b1);
    look("both_ok", 5, 0);

    upd(4'd5, 1'b0, 1'b1, 1'b0);
    upd(4'd5, 1'b0, 1'b0, 1'b1);
    look("both_bad", 5, 1);

    set_ghr(4'd9);
    look_upd("bypass", 4'd9, 1'b0, 1'b1, 1'b1, 9, 1);
    look_upd("indep", 4'd5, 1'b1, 1'b0, 1'b0, 3, 0);
    set_ghr(4'd5);
    look("indep_wr", 5, 0);

    lookup_valid = 1'b1;
    flush = 1'b1;
    set_upd(4'd3, 1'b0, 1'b1, 1'b1);
    tick();
    idle();
    check("flush.ready", ready, 0);
    check("flush.pred_valid", pred_valid, 0);
    wait_ready("flush_sweep", 16);
    look("flush_ghr", 0, 0);

    set_ghr(4'd9);
    look("sweep_clr", 9, 0);
    look_upd("pre_rst", 4'd9, 1'b0, 1'b1, 1'b1, 9, 1);

    flush = 1'b1;
    tick();
    idle();
    repeat (7) tick();
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst.ready", ready, 0);
    check("mid_rst.pred_valid", pred_valid, 0);
    check("mid_rst.pred_index", pred_index, 0);
    check("mid_rst.pred_global", pred_use_global, 0);
    tick();
    tick();
    reset = 1'b1;
    set_upd(4'd0, 1'b0, 1'b1, 1'b1);
    wait_ready("rst_sweep", 16);
    idle();
    look("init_upd_drop", 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/choice_table_predictor.md
Name: choice_table_predictor

Overview:
- Parametrised successor to the single-entry local/global chooser. It holds a table of 2^HIST_BITS saturating choice counters, indexed by a global history register (GHR), in the style of the Alpha 21264 choice predictor.
- Each lookup returns, one cycle later, whether the global or the local predictor should be trusted for that history.
- Resolved branches train the counters and shift the GHR.
- After reset or flush, a sequential init sweep clears the table.

Parameters:
- HIST_BITS, 12, GHR width; table depth = 2^HIST_BITS.
- CTR_BITS, 2, choice counter width (≥2).
- CTR_INIT, 1, counter value written by the init sweep (weakly local for CTR_BITS=2).

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset; the single clock is `clock`.
- flush  in  1  synchronous; clears GHR and restarts the init sweep.
- ready  out  1  high when the table is usable (RUN state).
- lookup_valid  in  1  lookup request; indexed by the current GHR.
- pred_valid  out  1  registered; high one cycle after an accepted lookup.
- pred_use_global  out  1  registered; counter MSB (1 = global, 0 = local).
- pred_index  out  HIST_BITS  registered; GHR value used, returned later on update.
- update_valid  in  1  resolved-branch training strobe.
- update_index  in  HIST_BITS  entry to train (pred_index from the lookup).
- update_local_correct  in  1  local predictor was right.
- update_global_correct  in  1  global predictor was right.
- update_taken  in  1  actual outcome; shifted into the GHR.

Behaviour:
- Reset (reset=0, asynchronous) drives the following:
  - state=INIT, init_ptr=0, GHR=0.
  - ready=0, pred_valid=0, pred_use_global=0, pred_index=0.
- FSM, two states:
  - INIT:
    - Writes CTR_INIT to entry init_ptr each cycle; init_ptr increments.
    - When init_ptr = 2^HIST_BITS-1 is written, moves to RUN next cycle.
    - The sweep takes exactly 2^HIST_BITS cycles.
    - ready=0; lookups are ignored (pred_valid stays 0); updates are dropped and the GHR is not shifted.
  - RUN:
    - ready=1.
    - flush=1 in any state: GHR←0, init_ptr←0, state←INIT, pred_valid←0 on the next edge. flush has priority over lookup and update in the same cycle.
- Lookup (RUN, lookup_valid=1):
  - On the next edge: pred_valid=1, pred_index=GHR (value before any same-cycle shift), pred_use_global=MSB of table[GHR].
  - pred_valid deasserts the following cycle unless there is another lookup. Latency is 1 cycle; there is no backpressure.
- Update (RUN, update_valid=1), counter rule:
  - If global_correct && !local_correct: counter+1, saturating at 2^CTR_BITS-1.
  - If local_correct && !global_correct: counter-1, saturating at 0.
  - Otherwise: no change.
  - The GHR always shifts: GHR ← {GHR[HIST_BITS-2:0], update_taken}.
- Same-cycle lookup and update to the same index: the prediction reflects the post-update counter (write-first bypass).
- Lookup and update to different indices in the same cycle proceed independently.
- The table has one write port; the write source is the sweep in INIT and the update in RUN.
- The table entries are not asynchronously reset; the sweep provides their initial value.
- Reset asserted mid-sweep or mid-operation returns the block to its reset values immediately; the sweep restarts from 0 after reset deasserts.

Decomposition:
- Shared package, choice_pkg:
  - FSM state enum {INIT, RUN}.
  - Function ctr_next(ctr, local_correct, global_correct) implementing the saturating rule.
  - Constants for the MSB-select meaning (LOCAL=0, GLOBAL=1).
- Sub-module choice_ctr_table:
  - 2^HIST_BITS × CTR_BITS storage.
  - One combinational read port and one synchronous write port.
  - Read-during-write forwarding.
- The top level holds the FSM, the GHR, the sweep pointer and the output registers.

Test Plan:
- Reset then idle, HIST_BITS=4: ready=0 for exactly 16 cycles after reset release, then ready=1. A lookup at idx 0 gives pred_use_global=0 (CTR_INIT=1).
- Two updates to idx 5 with global_correct=1, local_correct=0: counter goes 1→2→3. A lookup with GHR=5 gives pred_use_global=1. A third such update keeps the counter at 3 (saturation). Four local-only updates take it to 0 and no lower.
- Both predictors correct, and both wrong: the counter is unchanged in each case. The GHR still shifts; three updates with taken=1,0,1 from GHR=0 give pred_index=4'b0101.
- Lookup and update to the same idx in one cycle, counter=1, global-only correct: pred_use_global=1 the next cycle (bypass). pred_index equals the pre-shift GHR.
- Issue flush during RUN together with lookup_valid and update_valid: ready=0 the next cycle, pred_valid=0, GHR=0, the update is not applied, and the sweep repeats for 16 cycles.
- Assert reset mid-sweep at init_ptr=7: outputs go to reset values immediately. After release, the sweep takes the full 16 cycles, and updates issued during INIT leave counters at CTR_INIT.
